// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL layout,
// register-select decode and a byte-strobe merge helper.
package timer_pkg;

  // Byte offsets of the register file inside the 0x400-byte block.
  localparam logic [31:0] REG_CTRL     = 32'h0000_0000;
  localparam logic [31:0] REG_PRESCALE = 32'h0000_0004;
  localparam logic [31:0] REG_RELOAD   = 32'h0000_0008;
  localparam logic [31:0] REG_COUNT    = 32'h0000_000C;
  localparam logic [31:0] REG_STATUS   = 32'h0000_0010;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;

  // STATUS bit positions.
  localparam int STATUS_EXPIRED = 0;

  // CTRL register image; the first member lands in the MSB.
  typedef struct packed {
    logic irq_en;   // bit 2
    logic oneshot;  // bit 1
    logic en;       // bit 0
  } ctrl_t;

  // Which register an APB address selects.
  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_PRESCALE,
    SEL_RELOAD,
    SEL_COUNT,
    SEL_STATUS,
    SEL_NONE
  } reg_sel_t;

  // Map a byte address onto a register; the two low address bits are ignored.
  function automatic reg_sel_t decode_offset(input logic [31:0] offset);
    logic [31:0] word_addr;
    word_addr = offset & ~32'h3;
    case (word_addr)
      REG_CTRL:     return SEL_CTRL;
      REG_PRESCALE: return SEL_PRESCALE;
      REG_RELOAD:   return SEL_RELOAD;
      REG_COUNT:    return SEL_COUNT;
      REG_STATUS:   return SEL_STATUS;
      default:      return SEL_NONE;
    endcase
  endfunction

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the APB timer: divides clk by (i_prescale + 1) while enabled
// and flags the last cycle of each division period with o_tick.
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic                      i_clear,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_tick
);

  localparam logic [PRESCALE_WIDTH-1:0] PCNT_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  logic [PRESCALE_WIDTH-1:0] r_pcnt;

  // A tick is the cycle in which the running count has reached the terminal value.
  assign o_tick = i_en && (r_pcnt == i_prescale);

  // Count up to the terminal value and wrap; a terminal value lowered below
  // the running count just wraps to zero without producing a tick.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_pcnt <= '0;
    end else if (i_clear) begin
      r_pcnt <= '0;
    end else if (i_en) begin
      if (r_pcnt >= i_prescale) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + PCNT_ONE;
      end
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB completer timer: prescaled 32-bit down-counter with auto-reload or
// one-shot mode, sticky expiry flag, level interrupt and expiry strobe.
// Every access takes one wait state: accepted while pready is low, answered
// with a single-cycle pready pulse on the following cycle.
module apb_timer
  import timer_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 10,
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [31:0] RELOAD_DEFAULT = 32'hffff_ffff
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  input  logic [3:0]            pstrb,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  output logic                  irq,
  output logic                  expire_strobe
);

  // Register file and output flops.
  ctrl_t                     r_ctrl;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [31:0]               r_reload;
  logic [31:0]               r_count;
  logic                      r_expired;
  logic                      r_irq;
  logic                      r_expire_strobe;
  logic                      r_pready;
  logic [31:0]               r_prdata;
  logic                      r_pslverr;

  // Decode and next-value nets.
  reg_sel_t                  w_sel;
  logic                      w_access;
  logic                      w_wr;
  logic                      w_rd;
  logic                      w_err;
  logic                      w_wr_ctrl;
  logic                      w_wr_prescale;
  logic                      w_wr_reload;
  logic                      w_clr_status;
  logic                      w_en_rise;
  logic                      w_pcnt_clear;
  logic                      w_tick;
  logic                      w_expire;
  logic [31:0]               w_rdata;
  logic [31:0]               w_reload_new;
  logic [PRESCALE_WIDTH-1:0] w_prescale_new;
  ctrl_t                     w_ctrl_new;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  assign w_sel    = decode_offset(32'(paddr));
  assign w_access = psel && penable && !r_pready;
  assign w_wr     = w_access && pwrite;
  assign w_rd     = w_access && !pwrite;

  // Unmapped offsets and writes to the read-only COUNT answer with an error.
  assign w_err = (w_sel == SEL_NONE) || (pwrite && (w_sel == SEL_COUNT));

  assign w_wr_ctrl     = w_wr && (w_sel == SEL_CTRL);
  assign w_wr_prescale = w_wr && (w_sel == SEL_PRESCALE);
  assign w_wr_reload   = w_wr && (w_sel == SEL_RELOAD);
  assign w_clr_status  = w_wr && (w_sel == SEL_STATUS) && pstrb[0] && pwdata[STATUS_EXPIRED];

  // Read mux over the current register contents.
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned (no latch).
    w_rdata = '0;
    case (w_sel)
      SEL_CTRL: begin
        w_rdata[CTRL_EN]      = r_ctrl.en;
        w_rdata[CTRL_ONESHOT] = r_ctrl.oneshot;
        w_rdata[CTRL_IRQ_EN]  = r_ctrl.irq_en;
      end
      SEL_PRESCALE: w_rdata[PRESCALE_WIDTH-1:0] = r_prescale;
      SEL_RELOAD:   w_rdata = r_reload;
      SEL_COUNT:    w_rdata = r_count;
      SEL_STATUS:   w_rdata[STATUS_EXPIRED] = r_expired;
      default:      w_rdata = '0;
    endcase
  end

  // Byte-lane merged write values; all CTRL bits live in byte lane 0.
  always_comb begin
    w_ctrl_new = r_ctrl;
    if (pstrb[0]) begin
      w_ctrl_new.en      = pwdata[CTRL_EN];
      w_ctrl_new.oneshot = pwdata[CTRL_ONESHOT];
      w_ctrl_new.irq_en  = pwdata[CTRL_IRQ_EN];
    end
  end

  // PRESCALE merge, one strobe per eight bits of the register.
  always_comb begin
    w_prescale_new = r_prescale;
    for (int b = 0; b < PRESCALE_WIDTH; b++) begin
      if (pstrb[b/8]) begin
        w_prescale_new[b] = pwdata[b];
      end
    end
  end

  assign w_reload_new = strb_merge(r_reload, pwdata, pstrb);

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  // Restart the division period when the count is reloaded or the timer starts.
  assign w_en_rise    = w_wr_ctrl && w_ctrl_new.en && !r_ctrl.en;
  assign w_pcnt_clear = w_wr_reload || w_en_rise;

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_ctrl.en),
    .i_clear   (w_pcnt_clear),
    .i_prescale(r_prescale),
    .o_tick    (w_tick)
  );

  // A software reload in the same cycle overrides the tick, expiry included.
  assign w_expire = w_tick && (r_count == '0) && !w_wr_reload;

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  // APB response: pready pulses for one cycle after each accepted access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= w_access;
      r_prdata  <= w_rd ? w_rdata : '0;
      r_pslverr <= w_access && w_err;
    end
  end

  // Control registers; a CTRL write wins over the one-shot auto-disable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= w_ctrl_new;
      end else if (w_expire && r_ctrl.oneshot) begin
        r_ctrl.en <= 1'b0;
      end
      if (w_wr_prescale) begin
        r_prescale <= w_prescale_new;
      end
    end
  end

  // Down-counter: a RELOAD write loads both RELOAD and COUNT; otherwise each
  // tick decrements, wrapping from zero back to RELOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reload <= RELOAD_DEFAULT;
      r_count  <= RELOAD_DEFAULT;
    end else if (w_wr_reload) begin
      r_reload <= w_reload_new;
      r_count  <= w_reload_new;
    end else if (w_tick) begin
      r_count <= (r_count == '0) ? r_reload : r_count - 32'd1;
    end
  end

  // Expiry flag (set beats W1C), strobe and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_expired       <= 1'b0;
      r_expire_strobe <= 1'b0;
      r_irq           <= 1'b0;
    end else begin
      if (w_expire) begin
        r_expired <= 1'b1;
      end else if (w_clr_status) begin
        r_expired <= 1'b0;
      end
      r_expire_strobe <= w_expire;
      r_irq           <= r_expired && r_ctrl.irq_en;
    end
  end

  assign pready        = r_pready;
  assign prdata        = r_prdata;
  assign pslverr       = r_pslverr;
  assign irq           = r_irq;
  assign expire_strobe = r_expire_strobe;

endmodule

// File: tb/tb_apb_timer.sv
// Testbench for apb_timer: directed scenarios plus random APB traffic, with
// every output compared each cycle against a table-driven register model.
module tb_apb_timer;

  localparam logic [9:0] A_CTRL     = 10'h000;
  localparam logic [9:0] A_PRESCALE = 10'h004;
  localparam logic [9:0] A_RELOAD   = 10'h008;
  localparam logic [9:0] A_COUNT    = 10'h00C;
  localparam logic [9:0] A_STATUS   = 10'h010;

  // Writable bits of CTRL, PRESCALE, RELOAD, COUNT, STATUS (by word index).
  localparam logic [31:0] WMASK [0:4] = '{32'h0000_0007, 32'h0000_FFFF,
                                          32'hFFFF_FFFF, 32'h0, 32'h0};

  logic        clk = 1'b0;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        irq;
  logic        expire_strobe;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  time  t_ack;
  logic ack_irq;
  logic ack_strobe;
  logic last_err;

  always #5 clk = ~clk;

  apb_timer #(
    .ADDR_WIDTH    (10),
    .PRESCALE_WIDTH(16),
    .RELOAD_DEFAULT(32'hffff_ffff)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .pstrb        (pstrb),
    .pready       (pready),
    .prdata       (prdata),
    .pslverr      (pslverr),
    .irq          (irq),
    .expire_strobe(expire_strobe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: registers held as a word-indexed array, updated with the
  // timer rules once per clock from the bus inputs seen at that edge.
  // ---------------------------------------------------------------------------
  logic [31:0] m_regs [0:4];   // CTRL, PRESCALE, RELOAD, COUNT, STATUS
  int unsigned m_pcnt;
  logic        m_pready, m_pslverr, m_irq, m_strobe;
  logic [31:0] m_prdata;

  always @(posedge clk) begin : ref_model
    logic        acc, wr, bad, tick, expire, rl_wr, en_rise;
    int unsigned w;
    logic [31:0] lane, wm, rd, nv;
    if (rst) begin
      m_regs[0] <= 32'h0;
      m_regs[1] <= 32'h0;
      m_regs[2] <= 32'hffff_ffff;
      m_regs[3] <= 32'hffff_ffff;
      m_regs[4] <= 32'h0;
      m_pcnt    <= 0;
      m_pready  <= 1'b0;
      m_prdata  <= 32'h0;
      m_pslverr <= 1'b0;
      m_irq     <= 1'b0;
      m_strobe  <= 1'b0;
    end else begin
      acc     = psel && penable && !m_pready;
      wr      = acc && pwrite;
      w       = 32'(paddr) >> 2;
      bad     = (w > 4) || (pwrite && w == 3);
      rd      = (w <= 4) ? m_regs[w[2:0]] : 32'h0;
      lane    = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
      tick    = m_regs[0][0] && (m_pcnt == m_regs[1]);
      rl_wr   = wr && (w == 2);
      expire  = tick && (m_regs[3] == 0) && !rl_wr;
      en_rise = wr && (w == 0) && pstrb[0] && pwdata[0] && !m_regs[0][0];

      m_pready  <= acc;
      m_prdata  <= (acc && !pwrite) ? rd : 32'h0;
      m_pslverr <= acc && bad;

      if (wr && w == 0) begin
        wm = lane & WMASK[0];
        m_regs[0] <= (m_regs[0] & ~wm) | (pwdata & wm);
      end else if (expire && m_regs[0][1]) begin
        m_regs[0] <= m_regs[0] & ~32'h1;
      end

      if (wr && w == 1) begin
        wm = lane & WMASK[1];
        m_regs[1] <= (m_regs[1] & ~wm) | (pwdata & wm);
      end

      if (rl_wr) begin
        nv = (m_regs[2] & ~lane) | (pwdata & lane);
        m_regs[2] <= nv;
        m_regs[3] <= nv;
      end else if (tick) begin
        m_regs[3] <= (m_regs[3] == 0) ? m_regs[2] : m_regs[3] - 1;
      end

      if (expire) m_regs[4] <= 32'h1;
      else if (wr && w == 4 && pstrb[0] && pwdata[0]) m_regs[4] <= 32'h0;

      if (rl_wr || en_rise) m_pcnt <= 0;
      else if (m_regs[0][0]) m_pcnt <= (m_pcnt >= m_regs[1]) ? 0 : m_pcnt + 1;

      m_strobe <= expire;
      m_irq    <= m_regs[4][0] && m_regs[0][2];
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pready",        32'(pready),        32'(m_pready));
      check("prdata",        prdata,             m_prdata);
      check("pslverr",       32'(pslverr),       32'(m_pslverr));
      check("irq",           32'(irq),           32'(m_irq));
      check("expire_strobe", 32'(expire_strobe), 32'(m_strobe));
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks
  // ---------------------------------------------------------------------------
  task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pready) begin
        got = 1'b1;
        break;
      end
    end
    check("apb_ack", 32'(got), 32'h1);
    rdata      = prdata;
    err        = pslverr;
    ack_irq    = irq;
    ack_strobe = expire_strobe;
    t_ack      = $time;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("pready_one_cycle", 32'(pready), 32'h0);
  endtask

  task automatic apb_write(input logic [9:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    apb_xfer(1'b1, addr, data, 4'hF, rd, last_err);
  endtask

  task automatic apb_read(input logic [9:0] addr, output logic [31:0] data);
    apb_xfer(1'b0, addr, 32'h0, 4'hF, data, last_err);
  endtask

  task automatic wait_strobe(input int max_cyc, output time t, output bit seen);
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (expire_strobe) begin
        seen = 1'b1;
        t    = $time;
        break;
      end
    end
  endtask

  task automatic read_check(input string tag, input logic [9:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    check(tag, d, exp);
    check({tag, "_err"}, 32'(last_err), 32'h0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #600000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    logic        e;
    time         t_en, t1, t2;
    bit          seen;
    int          cnt;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pready",  32'(pready),        32'h0);
    check("rst_prdata",  prdata,             32'h0);
    check("rst_pslverr", 32'(pslverr),       32'h0);
    check("rst_irq",     32'(irq),           32'h0);
    check("rst_strobe",  32'(expire_strobe), 32'h0);

    // Reset values of all five registers.
    read_check("rst_ctrl",     A_CTRL,     32'h0);
    read_check("rst_prescale", A_PRESCALE, 32'h0);
    read_check("rst_reload",   A_RELOAD,   32'hffff_ffff);
    read_check("rst_count",    A_COUNT,    32'hffff_ffff);
    read_check("rst_status",   A_STATUS,   32'h0);

    // Periodic mode: (3+1)*(4+1) = 20 clocks per expiry.
    apb_write(A_PRESCALE, 32'd3);
    apb_write(A_RELOAD,   32'd4);
    apb_write(A_CTRL,     32'h5);
    t_en = t_ack;
    wait_strobe(40, t1, seen);
    check("first_strobe_seen", 32'(seen), 32'h1);
    check("first_expiry_clks", 32'((t1 - t_en) / 10), 32'd20);
    check("irq_with_strobe", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_one_after", 32'(irq), 32'h1);
    check("strobe_width", 32'(expire_strobe), 32'h0);
    wait_strobe(40, t2, seen);
    check("second_strobe_seen", 32'(seen), 32'h1);
    check("period_clks", 32'((t2 - t1) / 10), 32'd20);

    // W1C landing on the next expiry edge: the set wins.
    repeat (17) @(posedge clk);
    apb_write(A_STATUS, 32'h1);
    check("w1c_coincident", 32'(ack_strobe), 32'h1);
    read_check("status_set_wins", A_STATUS, 32'h1);
    for (int i = 0; i < 4; i++) begin
      apb_read(A_COUNT, d);   // value checked by the model
    end

    // Stop the timer, then a lone W1C clears EXPIRED and irq follows a cycle later.
    apb_write(A_CTRL, 32'h4);
    apb_write(A_STATUS, 32'h1);
    check("irq_before_clear", 32'(ack_irq), 32'h1);
    check("irq_after_clear",  32'(irq),     32'h0);
    read_check("status_cleared", A_STATUS, 32'h0);

    // One-shot: single strobe three clocks after enabling.
    apb_write(A_RELOAD,   32'd2);
    apb_write(A_PRESCALE, 32'd0);
    apb_write(A_CTRL,     32'h3);
    t_en = t_ack;
    wait_strobe(20, t1, seen);
    check("oneshot_seen", 32'(seen), 32'h1);
    check("oneshot_clks", 32'((t1 - t_en) / 10), 32'd3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (expire_strobe) cnt++;
    end
    check("oneshot_single", 32'(cnt), 32'h0);
    read_check("oneshot_ctrl",   A_CTRL,  32'h2);
    read_check("oneshot_count",  A_COUNT, 32'd2);
    read_check("oneshot_frozen", A_COUNT, 32'd2);

    // Error responses.
    apb_read(10'h014, d);
    check("bad_rd_err",  32'(last_err), 32'h1);
    check("bad_rd_data", d,             32'h0);
    apb_write(A_COUNT, 32'h1234_5678);
    check("count_wr_err", 32'(last_err), 32'h1);
    apb_xfer(1'b0, 10'h3FE, 32'h0, 4'hF, d, e);
    check("top_rd_err", 32'(e), 32'h1);
    read_check("count_unchanged", A_COUNT, 32'd2);

    // Reset during an accepted access while counting.
    apb_write(A_PRESCALE, 32'd1);
    apb_write(A_RELOAD,   32'd9);
    apb_write(A_CTRL,     32'h5);
    repeat (7) @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_COUNT; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pready) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_xfer_ack", 32'(seen), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pready",  32'(pready),        32'h0);
    check("midrst_prdata",  prdata,             32'h0);
    check("midrst_pslverr", 32'(pslverr),       32'h0);
    check("midrst_irq",     32'(irq),           32'h0);
    check("midrst_strobe",  32'(expire_strobe), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    read_check("midrst_ctrl",   A_CTRL,   32'h0);
    read_check("midrst_reload", A_RELOAD, 32'hffff_ffff);
    read_check("midrst_count",  A_COUNT,  32'hffff_ffff);
    read_check("midrst_status", A_STATUS, 32'h0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (expire_strobe) cnt++;
    end
    check("midrst_no_strobe", 32'(cnt), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 250; n++) begin
      logic [9:0]  a;
      logic [31:0] wd;
      logic [3:0]  st;
      logic        wr;
      int unsigned pick;
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1: begin
          a  = A_CTRL;
          wd = $urandom;
          if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
        end
        2, 3: begin
          a  = A_PRESCALE;
          wd = {($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000, 16'($urandom_range(0, 3))};
        end
        4, 5: begin
          a  = A_RELOAD;
          wd = 32'($urandom_range(0, 12));
        end
        6: begin
          a  = A_COUNT;
          wd = $urandom;
        end
        7, 8: begin
          a  = A_STATUS;
          wd = 32'($urandom_range(0, 3));
        end
        default: begin
          a  = 10'($urandom_range(5, 255) << 2);
          wd = $urandom;
        end
      endcase
      a  = a | 10'($urandom_range(0, 3));
      wr = ($urandom_range(0, 1) != 0);
      st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      apb_xfer(wr, a, wd, st, d, e);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      if ($urandom_range(0, 29) == 0) begin
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
